icap_reboot_seq: RTL and testbench



---
 rtl/icap_reboot_seq_pkg.sv | 32 +++
 rtl/icap_reboot_seq_rom.sv | 39 +++
 rtl/icap_reboot_seq.sv | 118 +++++++++++
 tb/tb_icap_reboot_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/icap_reboot_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : icap_reboot_seq_pkg
// Brief  : Spartan-6 IPROG (warm-boot) command words and sequencer state type.
// Rev    : 1.0
// ============================================================================
package icap_reboot_seq_pkg;

    localparam logic [15:0] SYNC0        = 16'hFFFF;
    localparam logic [15:0] SYNC1        = 16'hAA99;
    localparam logic [15:0] SYNC2        = 16'h5566;
    localparam logic [15:0] HDR_GENERAL1 = 16'h3261;
    localparam logic [15:0] HDR_GENERAL2 = 16'h3281;
    localparam logic [15:0] HDR_GENERAL3 = 16'h32A1;
    localparam logic [15:0] HDR_GENERAL4 = 16'h32C1;
    localparam logic [15:0] HDR_CMD      = 16'h30A1;
    localparam logic [15:0] CMD_IPROG    = 16'h000E;
    localparam logic [15:0] NOOP         = 16'h2000;
    localparam logic [7:0]  OPCODE_READ  = 8'h03;

    // Words before the trailing NOOPs.
    localparam int BASE_WORDS = 13;
    localparam int MAX_NOOPS  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_GAPWAIT = 2'd2
    } state_t;

endpackage : icap_reboot_seq_pkg
`default_nettype wire

// File: rtl/icap_reboot_seq_rom.sv
`default_nettype none
// ============================================================================
// Module : icap_seq_rom
// Brief  : Combinational index -> IPROG sequence word lookup.
// Rev    : 1.0
// ============================================================================
module icap_seq_rom
    import icap_reboot_seq_pkg::*;
#(
    parameter logic [23:0] GOLDEN = 24'h000000,
    parameter int          NOOPS  = 2
) (
    input  logic [4:0]  idx,
    input  logic [23:0] addr,
    output logic [15:0] word
);

    always_comb begin
        word = 16'h0000;
        case (idx)
            5'd0:    word = SYNC0;
            5'd1:    word = SYNC1;
            5'd2:    word = SYNC2;
            5'd3:    word = HDR_GENERAL1;
            5'd4:    word = addr[15:0];
            5'd5:    word = HDR_GENERAL2;
            5'd6:    word = {OPCODE_READ, addr[23:16]};
            5'd7:    word = HDR_GENERAL3;
            5'd8:    word = GOLDEN[15:0];
            5'd9:    word = HDR_GENERAL4;
            5'd10:   word = {OPCODE_READ, GOLDEN[23:16]};
            5'd11:   word = HDR_CMD;
            5'd12:   word = CMD_IPROG;
            default: word = (int'(idx) < BASE_WORDS + NOOPS) ? NOOP : 16'h0000;
        endcase
    end

endmodule : icap_seq_rom
`default_nettype wire

// File: rtl/icap_reboot_seq.sv
`default_nettype none
// ============================================================================
// Module : icap_reboot_seq
// Brief  : Issues the IPROG word sequence to the ICAP write stage, one word
//          every GAP cycles, with abort and synchronous reset.
// Rev    : 1.0
// ============================================================================
module icap_reboot_seq
    import icap_reboot_seq_pkg::*;
#(
    parameter int          GAP    = 16,
    parameter logic [23:0] GOLDEN = 24'h000000,
    parameter int          NOOPS  = 2
) (
    input  logic        c,
    input  logic        r,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic        abort,
    output logic        w,
    output logic [15:0] o,
    output logic        busy,
    output logic        done
);

    localparam int         N          = BASE_WORDS + NOOPS;
    localparam logic [4:0] C_LAST_IDX = 5'(N - 1);
    localparam logic [7:0] C_GAP_LOAD = 8'(GAP - 1);

    generate
        if (GAP < 16 || GAP > 255) begin : g_bad_gap
            $error("icap_reboot_seq: GAP out of range 16..255");
        end
        if (NOOPS < 0 || NOOPS > MAX_NOOPS) begin : g_bad_noops
            $error("icap_reboot_seq: NOOPS out of range 0..4");
        end
    endgenerate

    state_t      r_state;
    logic [4:0]  r_idx;
    logic [7:0]  r_cnt;
    logic [23:0] r_addr;
    logic [15:0] w_word;

    icap_seq_rom #(
        .GOLDEN (GOLDEN),
        .NOOPS  (NOOPS)
    ) u_rom (
        .idx  (r_idx),
        .addr (r_addr),
        .word (w_word)
    );

    // Outputs are registered on the edge that enters ISSUE, so the ROM is
    // addressed with the index of the word about to be issued. In IDLE the
    // index is 0, whose word does not depend on the address.
    always_ff @(posedge c) begin
        if (r) begin
            r_state <= ST_IDLE;
            r_idx   <= 5'd0;
            r_cnt   <= 8'd0;
            r_addr  <= 24'd0;
            w       <= 1'b0;
            o       <= 16'h0000;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            w    <= 1'b0;
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_addr  <= addr;
                        r_idx   <= 5'd0;
                        busy    <= 1'b1;
                        w       <= 1'b1;
                        o       <= w_word;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= C_GAP_LOAD;
                    if (abort || r_idx == C_LAST_IDX) begin
                        busy    <= 1'b0;
                        r_idx   <= 5'd0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx   <= r_idx + 5'd1;
                        r_state <= ST_GAPWAIT;
                    end
                end
                ST_GAPWAIT: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        r_idx   <= 5'd0;
                        r_cnt   <= 8'd0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == 8'd1) begin
                        r_cnt   <= 8'd0;
                        w       <= 1'b1;
                        o       <= w_word;
                        done    <= (r_idx == C_LAST_IDX);
                        r_state <= ST_ISSUE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_idx   <= 5'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : icap_reboot_seq
`default_nettype wire

// File: tb/tb_icap_reboot_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_icap_reboot_seq
// Brief  : Self-checking bench for two icap_reboot_seq builds against a
//          word-list / timing reference model.
// Rev    : 1.0
// ============================================================================
module tb_icap_reboot_seq;

    logic        c = 1'b0;
    logic        r_a, start_a, abort_a;
    logic [23:0] addr_a;
    logic        w_a, busy_a, done_a;
    logic [15:0] o_a;
    logic        r_b, start_b, abort_b;
    logic [23:0] addr_b;
    logic        w_b, busy_b, done_b;
    logic [15:0] o_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 c = ~c;

    icap_reboot_seq #(.GAP(16), .GOLDEN(24'h000000), .NOOPS(2)) dut_a (
        .c(c), .r(r_a), .start(start_a), .addr(addr_a), .abort(abort_a),
        .w(w_a), .o(o_a), .busy(busy_a), .done(done_a)
    );

    icap_reboot_seq #(.GAP(20), .GOLDEN(24'h0A0000), .NOOPS(0)) dut_b (
        .c(c), .r(r_b), .start(start_b), .addr(addr_b), .abort(abort_b),
        .w(w_b), .o(o_b), .busy(busy_b), .done(done_b)
    );

    task automatic tick;
        @(posedge c);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rs, input logic st,
                         input logic ab, input logic [23:0] ad);
        if (sel) begin r_b = rs; start_b = st; abort_b = ab; addr_b = ad; end
        else     begin r_a = rs; start_a = st; abort_a = ab; addr_a = ad; end
    endtask

    // One sequence on the selected build. stop_cyc < 0: run to completion;
    // otherwise abort (or reset) is held during cycle stop_cyc, counted from
    // the cycle of the first w. restart_cyc pulses a start with addr a2.
    task automatic run_seq(input bit sel, input logic [23:0] a, input int stop_cyc,
                           input bit stop_is_reset, input int restart_cyc,
                           input logic [23:0] a2);
        int          gap, n, last, stop_from, end_cyc;
        logic [23:0] g;
        logic [15:0] words[$];
        bit          ew, eb;
        logic        ow, ob, od;
        logic [15:0] oo;
        gap  = sel ? 20 : 16;
        n    = sel ? 13 : 15;
        g    = sel ? 24'h0A0000 : 24'h000000;
        last = (n - 1) * gap;
        words = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, a[15:0], 16'h3281,
                  {8'h03, a[23:16]}, 16'h32A1, g[15:0], 16'h32C1,
                  {8'h03, g[23:16]}, 16'h30A1, 16'h000E};
        for (int k = 13; k < n; k++) words.push_back(16'h2000);
        stop_from = (stop_cyc < 0) ? 32'h4000_0000 : stop_cyc + 1;
        end_cyc   = (stop_cyc < 0) ? last + 3 : stop_cyc + 4;

        drive(sel, 1'b0, 1'b1, 1'b0, a);
        tick();
        for (int cyc = 0; cyc <= end_cyc; cyc++) begin
            ow = sel ? w_b : w_a;
            ob = sel ? busy_b : busy_a;
            od = sel ? done_b : done_a;
            oo = sel ? o_b : o_a;
            ew = (cyc < stop_from) && (cyc % gap == 0) && (cyc / gap < n);
            eb = (cyc <= last) && (cyc < stop_from);
            check($sformatf("w[%0d]", cyc), 32'(ow), 32'(ew));
            check($sformatf("busy[%0d]", cyc), 32'(ob), 32'(eb));
            check($sformatf("done[%0d]", cyc), 32'(od), 32'(ew && cyc == last));
            if (ew)
                check($sformatf("o_word%0d", cyc / gap), 32'(oo), 32'(words[cyc / gap]));
            if (stop_is_reset && cyc == stop_from)
                check("o_after_reset", 32'(oo), 32'h0);
            drive(sel, stop_is_reset && cyc == stop_cyc, cyc == restart_cyc,
                  !stop_is_reset && cyc == stop_cyc,
                  (cyc == restart_cyc) ? a2 : 24'($urandom));
            tick();
        end
        drive(sel, 1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic idle_gap;
        repeat ($urandom_range(1, 5)) tick();
    endtask

    initial begin
        drive(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
        repeat (3) tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
        tick();
        check("rst_w_a", 32'(w_a), 32'h0);
        check("rst_o_a", 32'(o_a), 32'h0);
        check("rst_busy_a", 32'(busy_a), 32'h0);
        check("rst_done_a", 32'(done_a), 32'h0);
        check("rst_w_b", 32'(w_b), 32'h0);
        check("rst_o_b", 32'(o_b), 32'h0);
        check("rst_busy_b", 32'(busy_b), 32'h0);

        // Full sequence; a second start at the 4th word must be ignored.
        run_seq(1'b0, 24'h123456, -1, 1'b0, 3 * 16, 24'hABCDEF);
        idle_gap();
        // Abort 3 cycles after the 6th word, then a fresh full sequence.
        run_seq(1'b0, 24'($urandom), 5 * 16 + 3, 1'b0, -1, 24'h0);
        idle_gap();
        run_seq(1'b0, 24'($urandom), -1, 1'b0, -1, 24'h0);
        idle_gap();

        // start and abort together from IDLE are ignored.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 24'h654321);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("start_abort_busy%0d", i), 32'(busy_a), 32'h0);
            check($sformatf("start_abort_w%0d", i), 32'(w_a), 32'h0);
            tick();
        end

        // Second build: GAP=20, no NOOPs, nonzero golden address.
        run_seq(1'b1, 24'($urandom), -1, 1'b0, -1, 24'h0);
        idle_gap();
        run_seq(1'b1, 24'($urandom), 8 * 20 + 5, 1'b1, -1, 24'h0);
        idle_gap();
        run_seq(1'b1, 24'($urandom), -1, 1'b0, -1, 24'h0);
        idle_gap();

        // Abort at a random point inside a GAPWAIT.
        run_seq(1'b0, 24'($urandom), 2 * 16 + $urandom_range(1, 15), 1'b0, -1, 24'h0);
        idle_gap();
        run_seq(1'b0, 24'($urandom), -1, 1'b0, -1, 24'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_icap_reboot_seq
`default_nettype wire
